// File: rtl/register_file_mp.sv
// register_file_mp: NR combinational read ports, one write port, per-register pending scoreboard.
// Optional REGFILE_BYPASS_EN forwards a same-cycle write to matching read ports.
module register_file_mp #(
  parameter int D = 5,
  parameter int W = 32,
  parameter int NR = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            write_enable,
  input  logic [D-1:0]    address_w,
  input  logic [W-1:0]    write_data,
  input  logic            reserve_enable,
  input  logic [D-1:0]    address_rsv,
  input  logic [NR*D-1:0] address_r,
  output logic [NR*W-1:0] read_data,
  output logic [NR-1:0]   read_pending,
  output logic            err_unreserved
);
  localparam int N = 1 << D;
  logic [W-1:0] regs [N];
  logic [N-1:0] pend;
  logic err, we, rsv;
  assign we = write_enable && !(ZERO_REG != 0 && address_w == '0);
  assign rsv = reserve_enable && !(ZERO_REG != 0 && address_rsv == '0);
  assign err_unreserved = err;
  // reserve is assigned last so it wins over a same-address write clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      pend <= '0;
      err <= 1'b0;
    end else begin
      if (we) begin
        regs[address_w] <= write_data;
        pend[address_w] <= 1'b0;
        err <= err | ~pend[address_w];
      end
      if (rsv) pend[address_rsv] <= 1'b1;
    end
  for (genvar g = 0; g < NR; g++) begin : rd
    logic [D-1:0] a;
    logic z;
    assign a = address_r[g*D +: D];
    assign z = ZERO_REG != 0 && a == '0;
`ifdef REGFILE_BYPASS_EN
    logic byp;
    assign byp = we && address_w == a;
    assign read_data[g*W +: W] = z ? '0 : byp ? write_data : regs[a];
    assign read_pending[g] = !z && (byp ? rsv && address_rsv == a : pend[a]);
`else
    assign read_data[g*W +: W] = z ? '0 : regs[a];
    assign read_pending[g] = !z && pend[a];
`endif
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: vector table, corner-case sequences and randomized model check for register_file_mp.
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst_n, we, re;
  logic [4:0] aw, ars, a0, a1;
  logic [31:0] wd;
  logic [63:0] rd, rdz;
  logic [1:0] rp, rpz;
  logic err, errz;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  register_file_mp #(.D(5), .W(32), .NR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .address_w(aw), .write_data(wd),
    .reserve_enable(re), .address_rsv(ars), .address_r({a1, a0}),
    .read_data(rd), .read_pending(rp), .err_unreserved(err));
  register_file_mp #(.D(5), .W(32), .NR(2), .ZERO_REG(0)) dutz (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .address_w(aw), .write_data(wd),
    .reserve_enable(re), .address_rsv(ars), .address_r({a1, a0}),
    .read_data(rdz), .read_pending(rpz), .err_unreserved(errz));

  typedef struct {
    logic we; logic [4:0] aw; logic [31:0] wd; logic re; logic [4:0] ars, a0, a1;
    logic [31:0] e0, e1; logic p0, p1, er;
  } vec_t;
  vec_t tv[12];

  logic [31:0] m_reg [32];
  logic m_pend [32];
  logic m_err;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; aw = '0; ars = '0; wd = '0; a0 = '0; a1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // called just after a negedge: drive, take the edge, drop strobes, settle
  task automatic apply(input logic w, input logic [4:0] wa, input logic [31:0] d,
                       input logic r, input logic [4:0] ra);
    we = w; aw = wa; wd = d; re = r; ars = ra;
    @(posedge clk);
    #1 we = 1'b0; re = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && aw == a) return wd;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_rp(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && aw == a) return re && ars == a;
`endif
    return m_pend[a];
  endfunction

  initial begin
    tv[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  5'd4,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 5'd4,  32'h12345678, 1'b0, 5'd0,  5'd4,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 5'd0,  32'hAAAA5555, 1'b0, 5'd0,  5'd4,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 5'd15, 5'd15, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 5'd15, 32'hABCD1234, 1'b1, 5'd15, 5'd15, 5'd15, 32'hABCD1234, 32'hABCD1234, 1'b1, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 5'd15, 32'h11112222, 1'b0, 5'd0,  5'd15, 5'd15, 32'h11112222, 32'h11112222, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 5'd8,  32'hDEADBEEF, 1'b0, 5'd0,  5'd8,  5'd15, 32'hDEADBEEF, 32'h11112222, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd8,  5'd4,  32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b1};
    tv[9]  = tv[8];
    tv[10] = tv[8];
    tv[11] = '{1'b1, 5'd4,  32'h00000055, 1'b1, 5'd7,  5'd4,  5'd7,  32'h00000055, 32'h0,        1'b0, 1'b1, 1'b1};

    do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a0 = 5'd4;
    #1 chk("reset_rd0", rd[31:0], 32'h0);
    chk("reset_rp", {30'b0, rp}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a0 = tv[i].a0; a1 = tv[i].a1;
      apply(tv[i].we, tv[i].aw, tv[i].wd, tv[i].re, tv[i].ars);
      chk($sformatf("vec%0d_rd0", i), rd[31:0], tv[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd[63:32], tv[i].e1);
      chk($sformatf("vec%0d_rp0", i), {31'b0, rp[0]}, {31'b0, tv[i].p0});
      chk($sformatf("vec%0d_rp1", i), {31'b0, rp[1]}, {31'b0, tv[i].p1});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, tv[i].er});
    end

    // ZERO_REG=0 instance saw the same traffic: r0 written then reserved
    @(negedge clk);
    a1 = 5'd0;
    #1 chk("zr0_rd1", rdz[63:32], 32'hAAAA5555);
    chk("zr0_rp1", {31'b0, rpz[1]}, 32'h1);
    chk("zr0_err", {31'b0, errz}, 32'h1);

    // asynchronous reset mid-cycle with a write and reserve in flight
    @(negedge clk);
    a0 = 5'd4; a1 = 5'd5;
    apply(1'b1, 5'd4, 32'h12345678, 1'b0, 5'd0);
    chk("pre_rst_rd0", rd[31:0], 32'h12345678);
    @(negedge clk);
    #2 rst_n = 1'b0;
    we = 1'b1; aw = 5'd5; wd = 32'h1; re = 1'b1; ars = 5'd4;
    #1 chk("async_rst_rd0", rd[31:0], 32'h0);
    chk("async_rst_rp", {30'b0, rp}, 32'h0);
    chk("async_rst_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1 chk("rst_lost_rd1", rd[63:32], 32'h0);
    chk("rst_lost_rp", {30'b0, rp}, 32'h0);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    rst_n = 1'b1;

    // same-cycle bypass
    @(negedge clk);
    a0 = 5'd9; we = 1'b1; aw = 5'd9; wd = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre_rd0", rd[31:0], 32'hCAFEF00D);
`else
    chk("byp_pre_rd0", rd[31:0], 32'h0);
`endif
    chk("byp_pre_rp0", {31'b0, rp[0]}, 32'h0);
    re = 1'b1; ars = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rsv_rp0", {31'b0, rp[0]}, 32'h1);
`else
    chk("byp_rsv_rp0", {31'b0, rp[0]}, 32'h0);
`endif
    @(posedge clk);
    #1 we = 1'b0; re = 1'b0;
    #1 chk("byp_post_rd0", rd[31:0], 32'hCAFEF00D);
    chk("byp_post_rp0", {31'b0, rp[0]}, 32'h1);

    // randomized traffic against the architectural model
    do_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
    repeat (400) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      aw = 5'($urandom_range(0, 7));
      wd = $urandom;
      re = ($urandom_range(0, 2) == 0);
      ars = 5'($urandom_range(0, 7));
      a0 = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 7));
      #1;
      chk("rnd_rd0", rd[31:0], exp_rd(a0));
      chk("rnd_rd1", rd[63:32], exp_rd(a1));
      chk("rnd_rp", {30'b0, rp}, {30'b0, exp_rp(a1), exp_rp(a0)});
      chk("rnd_err", {31'b0, err}, {31'b0, m_err});
      @(posedge clk);
      if (we && aw != 0) begin
        m_reg[aw] = wd;
        if (!m_pend[aw]) m_err = 1'b1;
        m_pend[aw] = 1'b0;
      end
      if (re && ars != 0) m_pend[ars] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
